// File: rtl/sc_buttondebouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_buttondebouncer_pkg
// Description : Shared types and constants for the push-button debouncer.
//               Optional feature macro: SC_BUTTONDEBOUNCER_PULSE_EN
// Revision    : 1.0 - initial release
// ============================================================================
package sc_buttondebouncer_pkg;

    // Per-cell debounce state. The encoding is fixed, so the values are explicit.
    typedef enum logic [1:0] {
        STABLE_RELEASED = 2'd0,
        WAIT_PRESS      = 2'd1,
        STABLE_PRESSED  = 2'd2,
        WAIT_RELEASE    = 2'd3
    } db_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam int NUM_BUTTONS = 5;

    // Bit positions of each button in the packed press-pulse vector
    localparam int PULSE_START = 4;
    localparam int PULSE_UP    = 3;
    localparam int PULSE_DOWN  = 2;
    localparam int PULSE_LEFT  = 1;
    localparam int PULSE_RIGHT = 0;

    // Counter width that can hold every value from 0 to cycles inclusive
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : sc_buttondebouncer_pkg
`default_nettype wire

// File: rtl/sc_buttondebouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_buttondebouncer_if
// Description : Raw active-low button inputs and debounced outputs of the
//               button conditioner. Optional macro: SC_BUTTONDEBOUNCER_PULSE_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_buttondebouncer_if;

    logic SC_BUTTONDEBOUNCER_startButton_InLow;
    logic SC_BUTTONDEBOUNCER_upButton_InLow;
    logic SC_BUTTONDEBOUNCER_downButton_InLow;
    logic SC_BUTTONDEBOUNCER_leftButton_InLow;
    logic SC_BUTTONDEBOUNCER_rightButton_InLow;

    logic SC_BUTTONDEBOUNCER_startButton_OutLow;
    logic SC_BUTTONDEBOUNCER_upButton_OutLow;
    logic SC_BUTTONDEBOUNCER_downButton_OutLow;
    logic SC_BUTTONDEBOUNCER_leftButton_OutLow;
    logic SC_BUTTONDEBOUNCER_rightButton_OutLow;

`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
    logic [4:0] SC_BUTTONDEBOUNCER_pressPulse_Out;
`endif

    // Button source side: drives raw buttons, observes conditioned levels
    modport master (
        output SC_BUTTONDEBOUNCER_startButton_InLow,
        output SC_BUTTONDEBOUNCER_upButton_InLow,
        output SC_BUTTONDEBOUNCER_downButton_InLow,
        output SC_BUTTONDEBOUNCER_leftButton_InLow,
        output SC_BUTTONDEBOUNCER_rightButton_InLow,
        input  SC_BUTTONDEBOUNCER_startButton_OutLow,
        input  SC_BUTTONDEBOUNCER_upButton_OutLow,
        input  SC_BUTTONDEBOUNCER_downButton_OutLow,
        input  SC_BUTTONDEBOUNCER_leftButton_OutLow,
        input  SC_BUTTONDEBOUNCER_rightButton_OutLow
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
        ,
        input  SC_BUTTONDEBOUNCER_pressPulse_Out
`endif
    );

    // Debouncer side
    modport slave (
        input  SC_BUTTONDEBOUNCER_startButton_InLow,
        input  SC_BUTTONDEBOUNCER_upButton_InLow,
        input  SC_BUTTONDEBOUNCER_downButton_InLow,
        input  SC_BUTTONDEBOUNCER_leftButton_InLow,
        input  SC_BUTTONDEBOUNCER_rightButton_InLow,
        output SC_BUTTONDEBOUNCER_startButton_OutLow,
        output SC_BUTTONDEBOUNCER_upButton_OutLow,
        output SC_BUTTONDEBOUNCER_downButton_OutLow,
        output SC_BUTTONDEBOUNCER_leftButton_OutLow,
        output SC_BUTTONDEBOUNCER_rightButton_OutLow
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
        ,
        output SC_BUTTONDEBOUNCER_pressPulse_Out
`endif
    );

endinterface : sc_buttondebouncer_if
`default_nettype wire

// File: rtl/sc_debouncecell.sv
`default_nettype none
// ============================================================================
// Module      : sc_debouncecell
// Description : One button: two-flop synchronizer, stability counter, state
//               register and, with SC_BUTTONDEBOUNCER_PULSE_EN, a press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_debouncecell
    import sc_buttondebouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw_n,
    output logic      level_n
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
    ,
    output logic      press_pulse
`endif
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_state;
    db_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= STABLE_RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    // The counter only advances while below CNT_MAX, so it cannot wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            STABLE_RELEASED: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_PRESS;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (r_sync2) begin
                    w_state_nxt = STABLE_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = STABLE_PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            STABLE_PRESSED: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_RELEASE;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (!r_sync2) begin
                    w_state_nxt = STABLE_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = STABLE_RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_level_nxt = (w_state_nxt == STABLE_RELEASED) || (w_state_nxt == WAIT_PRESS);
    assign level_n     = r_level;

`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
    logic r_pulse;

    // Fires on the same edge that drives the level low, so both appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (r_state == WAIT_PRESS) && (w_state_nxt == STABLE_PRESSED);
        end
    end

    assign press_pulse = r_pulse;
`endif

endmodule : sc_debouncecell
`default_nettype wire

// File: rtl/sc_buttondebouncer.sv
`default_nettype none
// ============================================================================
// Module      : sc_buttondebouncer
// Description : Five independent debounce cells for start/up/down/left/right.
//               Optional macro: SC_BUTTONDEBOUNCER_PULSE_EN adds pressPulse_Out.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_buttondebouncer
    import sc_buttondebouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic            SC_BUTTONDEBOUNCER_CLOCK_50,
    input  wire logic            SC_BUTTONDEBOUNCER_RESET_InHigh,
    sc_buttondebouncer_if.slave  btn
);

    logic [NUM_BUTTONS-1:0] w_raw_n;
    logic [NUM_BUTTONS-1:0] w_level_n;
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
    logic [NUM_BUTTONS-1:0] w_pulse;
`endif

    assign w_raw_n[PULSE_START] = btn.SC_BUTTONDEBOUNCER_startButton_InLow;
    assign w_raw_n[PULSE_UP]    = btn.SC_BUTTONDEBOUNCER_upButton_InLow;
    assign w_raw_n[PULSE_DOWN]  = btn.SC_BUTTONDEBOUNCER_downButton_InLow;
    assign w_raw_n[PULSE_LEFT]  = btn.SC_BUTTONDEBOUNCER_leftButton_InLow;
    assign w_raw_n[PULSE_RIGHT] = btn.SC_BUTTONDEBOUNCER_rightButton_InLow;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_cell
        sc_debouncecell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk         (SC_BUTTONDEBOUNCER_CLOCK_50),
            .rst         (SC_BUTTONDEBOUNCER_RESET_InHigh),
            .raw_n       (w_raw_n[gi]),
            .level_n     (w_level_n[gi])
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
            ,
            .press_pulse (w_pulse[gi])
`endif
        );
    end

    assign btn.SC_BUTTONDEBOUNCER_startButton_OutLow = w_level_n[PULSE_START];
    assign btn.SC_BUTTONDEBOUNCER_upButton_OutLow    = w_level_n[PULSE_UP];
    assign btn.SC_BUTTONDEBOUNCER_downButton_OutLow  = w_level_n[PULSE_DOWN];
    assign btn.SC_BUTTONDEBOUNCER_leftButton_OutLow  = w_level_n[PULSE_LEFT];
    assign btn.SC_BUTTONDEBOUNCER_rightButton_OutLow = w_level_n[PULSE_RIGHT];

`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
    assign btn.SC_BUTTONDEBOUNCER_pressPulse_Out = w_pulse;
`endif

endmodule : sc_buttondebouncer
`default_nettype wire

// File: tb/tb_sc_buttondebouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_buttondebouncer
// Description : Self-checking bench for sc_buttondebouncer, DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_buttondebouncer;

    localparam int DB = 4;

    logic clk;
    logic rst;

    sc_buttondebouncer_if bif ();

    sc_buttondebouncer #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .SC_BUTTONDEBOUNCER_CLOCK_50     (clk),
        .SC_BUTTONDEBOUNCER_RESET_InHigh (rst),
        .btn                             (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order everywhere: [4]=start [3]=up [2]=down [1]=left [0]=right
    typedef struct {
        string      tag;
        logic       rst;
        logic [4:0] btn;
        logic [4:0] exp_out;
        logic [4:0] exp_pulse;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic void add(input string tag, input logic r, input logic [4:0] b,
                                input logic [4:0] eo, input logic [4:0] ep, input int n);
        vec_t v;
        v.tag = tag; v.rst = r; v.btn = b; v.exp_out = eo; v.exp_pulse = ep;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [4:0] b);
        rst = r;
        bif.SC_BUTTONDEBOUNCER_startButton_InLow = b[4];
        bif.SC_BUTTONDEBOUNCER_upButton_InLow    = b[3];
        bif.SC_BUTTONDEBOUNCER_downButton_InLow  = b[2];
        bif.SC_BUTTONDEBOUNCER_leftButton_InLow  = b[1];
        bif.SC_BUTTONDEBOUNCER_rightButton_InLow = b[0];
    endtask

    function automatic logic [4:0] outs();
        return {bif.SC_BUTTONDEBOUNCER_startButton_OutLow,
                bif.SC_BUTTONDEBOUNCER_upButton_OutLow,
                bif.SC_BUTTONDEBOUNCER_downButton_OutLow,
                bif.SC_BUTTONDEBOUNCER_leftButton_OutLow,
                bif.SC_BUTTONDEBOUNCER_rightButton_OutLow};
    endfunction

    task automatic check(input string tag, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", tag, idx, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, sample one time unit after the rising edge.
    task automatic step(input string tag, input int idx, input logic r, input logic [4:0] b,
                        input logic [4:0] eo, input logic [4:0] ep);
        @(negedge clk);
        drive(r, b);
        @(posedge clk);
        #1;
        check({tag, "_out"}, idx, outs(), eo);
`ifdef SC_BUTTONDEBOUNCER_PULSE_EN
        check({tag, "_pulse"}, idx, bif.SC_BUTTONDEBOUNCER_pressPulse_Out, ep);
`else
        if (ep === 5'bxxxxx) errors++;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 5'b11111);

        add("reset",       1'b1, 5'b11111, 5'b11111, 5'b00000, 3);
        add("idle",        1'b0, 5'b11111, 5'b11111, 5'b00000, 20);
        // up: raw low at edge 0, output low from edge 6
        add("up_wait",     1'b0, 5'b10111, 5'b11111, 5'b00000, 6);
        add("up_press",    1'b0, 5'b10111, 5'b10111, 5'b01000, 1);
        add("up_hold",     1'b0, 5'b10111, 5'b10111, 5'b00000, 3);
        add("up_relwait",  1'b0, 5'b11111, 5'b10111, 5'b00000, 6);
        add("up_rel",      1'b0, 5'b11111, 5'b11111, 5'b00000, 3);
        // short glitch (DB-1 synchronized lows) must not reach the output
        add("glitch",      1'b0, 5'b10111, 5'b11111, 5'b00000, 3);
        add("glitch_end",  1'b0, 5'b11111, 5'b11111, 5'b00000, 8);
        // left bounce 0,0,0,1 then held 0; final fall at relative edge 4
        add("left_bnc",    1'b0, 5'b11101, 5'b11111, 5'b00000, 3);
        add("left_bnc",    1'b0, 5'b11111, 5'b11111, 5'b00000, 1);
        add("left_wait",   1'b0, 5'b11101, 5'b11111, 5'b00000, 6);
        add("left_press",  1'b0, 5'b11101, 5'b11101, 5'b00010, 1);
        add("left_hold",   1'b0, 5'b11101, 5'b11101, 5'b00000, 2);
        add("left_relw",   1'b0, 5'b11111, 5'b11101, 5'b00000, 6);
        add("left_rel",    1'b0, 5'b11111, 5'b11111, 5'b00000, 2);
        // down press, then release bounce 1,0,1 held; last rise at relative edge 2
        add("down_wait",   1'b0, 5'b11011, 5'b11111, 5'b00000, 6);
        add("down_press",  1'b0, 5'b11011, 5'b11011, 5'b00100, 1);
        add("down_hold",   1'b0, 5'b11011, 5'b11011, 5'b00000, 3);
        add("down_rbnc",   1'b0, 5'b11111, 5'b11011, 5'b00000, 1);
        add("down_rbnc",   1'b0, 5'b11011, 5'b11011, 5'b00000, 1);
        add("down_relw",   1'b0, 5'b11111, 5'b11011, 5'b00000, 6);
        add("down_rel",    1'b0, 5'b11111, 5'b11111, 5'b00000, 3);
        // start and right together
        add("sr_wait",     1'b0, 5'b01110, 5'b11111, 5'b00000, 6);
        add("sr_press",    1'b0, 5'b01110, 5'b01110, 5'b10001, 1);
        add("sr_hold",     1'b0, 5'b01110, 5'b01110, 5'b00000, 2);
        add("sr_relw",     1'b0, 5'b11111, 5'b01110, 5'b00000, 6);
        add("sr_rel",      1'b0, 5'b11111, 5'b11111, 5'b00000, 2);

        foreach (vecs[i])
            step(vecs[i].tag, i, vecs[i].rst, vecs[i].btn, vecs[i].exp_out, vecs[i].exp_pulse);

        // Reset in the middle of a right-button count discards the count
        for (int k = 0; k < 4; k++)
            step("rmid_pre", k, 1'b0, 5'b11110, 5'b11111, 5'b00000);
        step("rmid_rst", 4, 1'b1, 5'b11110, 5'b11111, 5'b00000);
        for (int k = 0; k < 7; k++)
            step("rmid_post", k, 1'b0, 5'b11110,
                 (k < 6) ? 5'b11111 : 5'b11110,
                 (k == 6) ? 5'b00001 : 5'b00000);
        for (int k = 0; k < 6; k++)
            step("rmid_relw", k, 1'b0, 5'b11111, 5'b11110, 5'b00000);
        step("rmid_rel", 6, 1'b0, 5'b11111, 5'b11111, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sc_buttondebouncer
`default_nettype wire
